alu_arbiter: RTL and testbench

- Shares one instance of the team's 32-bit combinational ALU (`alu`) between two requesters.
- Each requester sends (a, b, op, tag) over a valid/ready channel. The block grants one request at a time, latches its operands, and runs the ALU for one cycle.
- The registered result returns on a single response channel, tagged with the winning port.
- Sits between the multi-cycle execute/address-generation units and the shared ALU.

---
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port valid/ready arbiter sharing one ALU; define ALU_ARB_STATS_EN for per-port accept counters
module alu (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  always_comb
    y = op == 3'b110 ? a - b :
        op == 3'b000 ? a & b :
        op == 3'b001 ? a | b :
        op == 3'b011 ? a ^ b :
        op == 3'b111 ? {31'd0, a < b} : a + b;
endmodule

module alu_arbiter #(
  parameter int TAG_W      = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_port,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      stat_cnt0,
  output logic [15:0]      stat_cnt1
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, grant, accept;
  logic [31:0] op_a, op_b, alu_y;
  logic [2:0] op_c;
  logic [TAG_W-1:0] op_tag;
  logic op_port;
  alu u_alu (.op(op_c), .a(op_a), .b(op_b), .y(alu_y));
  always_comb begin
    grant = req0_valid & req1_valid ? (FIXED_PRIO ? 1'b0 : ~last_grant) : req1_valid;
    req0_ready = state == IDLE & ~grant & req0_valid;
    req1_ready = state == IDLE & grant & req1_valid;
    accept = req0_ready | req1_ready;
    state_nx = state == IDLE ? (accept ? EXEC : IDLE) :
               state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      op_a <= '0;
      op_b <= '0;
      op_c <= '0;
      op_tag <= '0;
      op_port <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
      rsp_port <= 1'b0;
      rsp_tag <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_a <= grant ? req1_a : req0_a;
        op_b <= grant ? req1_b : req0_b;
        op_c <= grant ? req1_op : req0_op;
        op_tag <= grant ? req1_tag : req0_tag;
        op_port <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_result <= alu_y;
        rsp_zero <= alu_y == 32'd0;
        rsp_port <= op_port;
        rsp_tag <= op_tag;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready)
        rsp_valid <= 1'b0;
    end
  end
`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else begin
      if (req0_ready && !(&stat_cnt0)) stat_cnt0 <= stat_cnt0 + 16'd1;
      if (req1_ready && !(&stat_cnt1)) stat_cnt1 <= stat_cnt1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: round-robin and fixed-priority instances checked each cycle against a transaction-level model
module tb_alu_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic v0[2], v1[2], rd0[2], rd1[2], rr[2], rv[2], rz[2], rp[2], bsy[2];
  logic [31:0] a0[2], b0[2], a1[2], b1[2], res[2];
  logic [2:0] op0[2], op1[2];
  logic [3:0] t0[2], t1[2], rt[2];
`ifdef ALU_ARB_STATS_EN
  logic [15:0] sc0[2], sc1[2];
`endif
  for (genvar g = 0; g < 2; g++) begin : gi
    alu_arbiter #(.TAG_W(4), .FIXED_PRIO(g == 1)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(v0[g]), .req0_ready(rd0[g]), .req0_a(a0[g]), .req0_b(b0[g]), .req0_op(op0[g]), .req0_tag(t0[g]),
      .req1_valid(v1[g]), .req1_ready(rd1[g]), .req1_a(a1[g]), .req1_b(b1[g]), .req1_op(op1[g]), .req1_tag(t1[g]),
      .rsp_valid(rv[g]), .rsp_ready(rr[g]), .rsp_result(res[g]), .rsp_zero(rz[g]), .rsp_port(rp[g]), .rsp_tag(rt[g]),
      .busy(bsy[g])
`ifdef ALU_ARB_STATS_EN
      , .stat_cnt0(sc0[g]), .stat_cnt1(sc1[g])
`endif
    );
  end
  bit pv[2][2], acc[2][2];
  logic [31:0] pa[2][2], pb[2][2];
  logic [2:0] pop[2][2];
  logic [3:0] ptg[2][2];
  bit rnd, full;
  int rr_force;
  int glog[2][8], gn[2], busy_cyc[2];
  int stg[2], mc[2][2];
  bit mlast[2], mrv[2], mz[2], mp[2], lp[2];
  logic [31:0] mres[2], la[2], lb[2];
  logic [2:0] lop[2];
  logic [3:0] lt[2], mt[2];
  int n_cmp, n_bad;

  function automatic logic [31:0] ref_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'b110: return a - b;
      3'b000: return a & b;
      3'b001: return a | b;
      3'b011: return a ^ b;
      3'b111: return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset(int k);
    stg[k] = 0; mlast[k] = 1'b1; mrv[k] = 1'b0; mres[k] = '0;
    mz[k] = 1'b0; mp[k] = 1'b0; mt[k] = '0; mc[k][0] = 0; mc[k][1] = 0;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    return $urandom_range(3, 0) == 0 ? 32'($urandom_range(3, 0)) : 32'($urandom());
  endfunction

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pv[k][p] && (full || (rnd && $urandom_range(1, 0) == 1))) begin
          pv[k][p] = 1'b1; pa[k][p] = rnd_opnd(); pb[k][p] = rnd_opnd();
          pop[k][p] = 3'($urandom_range(7, 0)); ptg[k][p] = 4'($urandom_range(15, 0));
        end
      v0[k] = pv[k][0] && !reset && !(rnd && $urandom_range(7, 0) == 0);
      v1[k] = pv[k][1] && !reset && !(rnd && $urandom_range(7, 0) == 0);
      a0[k] = pa[k][0]; b0[k] = pb[k][0]; op0[k] = pop[k][0]; t0[k] = ptg[k][0];
      a1[k] = pa[k][1]; b1[k] = pb[k][1]; op1[k] = pop[k][1]; t1[k] = ptg[k][1];
      rr[k] = rr_force < 0 ? $urandom_range(2, 0) != 0 : rr_force[0];
    end
  endtask

  task automatic set_req(int p, logic [31:0] a, logic [31:0] b, logic [2:0] op, logic [3:0] tag);
    for (int k = 0; k < 2; k++) begin
      pv[k][p] = 1'b1; pa[k][p] = a; pb[k][p] = b; pop[k][p] = op; ptg[k][p] = tag;
    end
    drive();
  endtask

  task automatic step();
    bit g, e0, e1;
    int p;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      g = (v0[k] && v1[k]) ? (k == 1 ? 1'b0 : !mlast[k]) : v1[k];
      e0 = stg[k] == 0 && !g && v0[k];
      e1 = stg[k] == 0 && g && v1[k];
      check($sformatf("req0_ready[%0d]", k), rd0[k], e0);
      check($sformatf("req1_ready[%0d]", k), rd1[k], e1);
      check($sformatf("busy[%0d]", k), bsy[k], stg[k] != 0);
      check($sformatf("rsp_valid[%0d]", k), rv[k], mrv[k]);
      check($sformatf("rsp_result[%0d]", k), res[k], mres[k]);
      check($sformatf("rsp_zero[%0d]", k), rz[k], mz[k]);
      check($sformatf("rsp_port[%0d]", k), rp[k], mp[k]);
      check($sformatf("rsp_tag[%0d]", k), rt[k], mt[k]);
`ifdef ALU_ARB_STATS_EN
      check($sformatf("stat_cnt0[%0d]", k), sc0[k], mc[k][0]);
      check($sformatf("stat_cnt1[%0d]", k), sc1[k], mc[k][1]);
`endif
      acc[k][0] = e0 && !reset;
      acc[k][1] = e1 && !reset;
      if (bsy[k]) busy_cyc[k]++;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) model_reset(k);
      else if (stg[k] == 0) begin
        if (acc[k][0] || acc[k][1]) begin
          p = acc[k][1] ? 1 : 0;
          la[k] = pa[k][p]; lb[k] = pb[k][p]; lop[k] = pop[k][p]; lt[k] = ptg[k][p];
          lp[k] = p[0]; mlast[k] = p[0]; pv[k][p] = 1'b0;
          if (mc[k][p] < 65535) mc[k][p]++;
          if (gn[k] < 8) glog[k][gn[k]] = p;
          gn[k]++;
          stg[k] = 1;
        end
      end else if (stg[k] == 1) begin
        mres[k] = ref_alu(lop[k], la[k], lb[k]);
        mz[k] = mres[k] == 0; mp[k] = lp[k]; mt[k] = lt[k]; mrv[k] = 1'b1; stg[k] = 2;
      end else if (rr[k]) begin
        mrv[k] = 1'b0; stg[k] = 0;
      end
    end
    #1 drive();
  endtask

  task automatic run_until_idle();
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 200) begin
      step();
      n++;
      done = 1'b1;
      for (int k = 0; k < 2; k++)
        if (stg[k] != 0 || pv[k][0] || pv[k][1]) done = 1'b0;
    end
    check("drain", done, 1);
  endtask

  task automatic check_rsp(string tag, logic [31:0] r, bit z, bit p, logic [3:0] t);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_result[%0d]", tag, k), res[k], r);
      check($sformatf("%s_zero[%0d]", tag, k), rz[k], z);
      check($sformatf("%s_port[%0d]", tag, k), rp[k], p);
      check($sformatf("%s_tag[%0d]", tag, k), rt[k], t);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; rnd = 0; full = 0; rr_force = 1; reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      gn[k] = 0; busy_cyc[k] = 0; model_reset(k);
      for (int p = 0; p < 2; p++) begin
        pv[k][p] = 1'b0; pa[k][p] = '0; pb[k][p] = '0; pop[k][p] = '0; ptg[k][p] = '0;
      end
    end
    drive();
    @(posedge clk);
    #1;
    repeat (2) step();
    reset = 1'b0;
    drive();
    step();
    for (int k = 0; k < 2; k++) busy_cyc[k] = 0;
    set_req(0, 32'd5, 32'd7, 3'b010, 4'd3);
    run_until_idle();
    check_rsp("add", 32'd12, 1'b0, 1'b0, 4'd3);
    for (int k = 0; k < 2; k++) check($sformatf("busy_cycles[%0d]", k), busy_cyc[k], 2);
    set_req(1, 32'd9, 32'd9, 3'b110, 4'd5);
    run_until_idle();
    check_rsp("sub", 32'd0, 1'b1, 1'b1, 4'd5);
    rr_force = 0;
    set_req(0, 32'hF0F0F0F0, 32'hFFFF0000, 3'b011, 4'd7);
    step();
    set_req(1, 32'hFFFFFFFF, 32'd1, 3'b111, 4'd9);
    repeat (6) step();
    check_rsp("xor_stall", 32'h0F0FF0F0, 1'b0, 1'b0, 4'd7);
    for (int k = 0; k < 2; k++) check($sformatf("xor_stall_valid[%0d]", k), rv[k], 1);
    rr_force = 1;
    drive();
    run_until_idle();
    check_rsp("sltu", 32'd0, 1'b1, 1'b1, 4'd9);
    set_req(0, 32'd2, 32'd3, 3'b100, 4'd1);
    run_until_idle();
    check_rsp("op100", 32'd5, 1'b0, 1'b0, 4'd1);
`ifdef ALU_ARB_STATS_EN
    for (int k = 0; k < 2; k++) begin
      check($sformatf("stats0[%0d]", k), sc0[k], 3);
      check($sformatf("stats1[%0d]", k), sc1[k], 2);
    end
`endif
    set_req(0, 32'd1, 32'd1, 3'b010, 4'd2);
    step();
    reset = 1'b1;
    drive();
    step();
    reset = 1'b0;
    drive();
    repeat (4) step();
    for (int k = 0; k < 2; k++) check($sformatf("killed_valid[%0d]", k), rv[k], 0);
    for (int k = 0; k < 2; k++) gn[k] = 0;
    full = 1;
    drive();
    for (int n = 0; n < 60 && (gn[0] < 4 || gn[1] < 4); n++) step();
    full = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant[%0d]", i), glog[0][i], i % 2);
      check($sformatf("fp_grant[%0d]", i), glog[1][i], 0);
    end
    run_until_idle();
    rnd = 1; rr_force = -1;
    repeat (3000) step();
    rnd = 0; rr_force = 1;
    drive();
    run_until_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
